// File: rtl/kernel_dupn.sv
// N-way stream duplicator: each input word is delivered once to every output.
// Optional per-word output enable mask is built when KERNEL_DUPN_MASK_EN is defined.
module kernel_dupn #(
    parameter int WIDTH = 32,
    parameter int N_OUT = 2,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       input_data,
    input  logic                   input_avail,
    output logic                   input_read,
    output logic [N_OUT*WIDTH-1:0] output_data,
    output logic [N_OUT-1:0]       output_write,
    input  logic [N_OUT-1:0]       output_full,
`ifdef KERNEL_DUPN_MASK_EN
    input  logic [N_OUT-1:0]       output_enable,
`endif
    output logic                   running
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [N_OUT-1:0] r_pending;
    logic             r_running;

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic [N_OUT-1:0] w_left;
    logic [N_OUT-1:0] w_new_mask;
    logic [CW-1:0]    w_count_next;
    logic [AW-1:0]    w_head_next;

    // Handshakes are gated by rst directly so nothing moves during the reset cycle.
    assign w_push       = !rst && input_avail && (r_count < FULL_COUNT);
    assign input_read   = w_push;
    assign output_write = (!rst && r_count != '0) ? (r_pending & ~output_full) : '0;

    assign w_left       = r_pending & ~output_write;
    assign w_pop        = (r_count != '0) && (w_left == '0);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head_next  = w_pop ? r_head + AW'(1) : r_head;
    assign w_load       = (r_count == '0 && w_push) || (w_pop && w_count_next != '0);

`ifdef KERNEL_DUPN_MASK_EN
    logic [N_OUT-1:0] r_mask [DEPTH];

    // The word about to become head may be the one being pushed this very cycle.
    assign w_new_mask = (w_push && w_head_next == r_tail) ? output_enable : r_mask[w_head_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask[r_tail] <= output_enable;
        end
    end
`else
    assign w_new_mask = '1;
`endif

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign output_data[g*WIDTH +: WIDTH] = r_buf[r_head];
    end

    assign running = r_running;

    // NOTE: buffer storage has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_tail] <= input_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_running <= 1'b1;
        end else begin
            r_head    <= w_head_next;
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            r_count   <= w_count_next;
            r_pending <= w_load ? w_new_mask : w_left;
            r_running <= input_avail || (w_count_next != '0);
        end
    end

endmodule

// File: tb/tb_kernel_dupn.sv
// Self-checking bench for kernel_dupn: per-output scoreboard queues filled on
// input reads and drained on output writes, plus cycle-exact handshake checks.
module tb_kernel_dupn;
    localparam int WIDTH = 32;
    localparam int N_OUT = 3;
    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WIDTH-1:0]       input_data;
    logic                   input_avail;
    logic                   input_read;
    logic [N_OUT*WIDTH-1:0] output_data;
    logic [N_OUT-1:0]       output_write;
    logic [N_OUT-1:0]       output_full;
    logic                   running;
`ifdef KERNEL_DUPN_MASK_EN
    logic [N_OUT-1:0]       output_enable;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q [N_OUT][$];

    kernel_dupn #(.WIDTH(WIDTH), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_avail  (input_avail),
        .input_read   (input_read),
        .output_data  (output_data),
        .output_write (output_write),
        .output_full  (output_full),
`ifdef KERNEL_DUPN_MASK_EN
        .output_enable(output_enable),
`endif
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pending_words();
        int n = 0;
        for (int i = 0; i < N_OUT; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Writes are scored before reads so a same-cycle pass-through is caught.
    task automatic monitor();
        logic [N_OUT-1:0] mask;
        logic [WIDTH-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_read", 64'(input_read), 64'd0);
                check("rst_write", 64'(output_write), 64'd0);
                for (int i = 0; i < N_OUT; i++) exp_q[i].delete();
            end else begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (output_write[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check("unexpected_write", 64'(i + 1), 64'd0);
                        end else begin
                            exp = exp_q[i].pop_front();
                            check("out_data", 64'(output_data[i*WIDTH +: WIDTH]), 64'(exp));
                        end
                    end
                end
`ifdef KERNEL_DUPN_MASK_EN
                mask = output_enable;
`else
                mask = '1;
`endif
                if (input_read) begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (mask[i]) exp_q[i].push_back(input_data);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (pending_words() != 0 && k < 100) begin
            step();
            k++;
        end
        check("drain", 64'(pending_words()), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        input_data  = '0;
        input_avail = 1'b0;
        output_full = '0;
`ifdef KERNEL_DUPN_MASK_EN
        output_enable = '1;
`endif
        fork
            monitor();
        join_none
        step();
        step();
        rst = 1'b0;
        mid();
        check("reset_running", 64'(running), 64'd1);
        check("reset_read", 64'(input_read), 64'd0);
        check("reset_write", 64'(output_write), 64'd0);

        // Back-to-back 5, 6, 7 with outputs never full, then idle behaviour.
        step(); input_data = 5; input_avail = 1'b1;
        mid();  check("t1_read0", 64'(input_read), 64'd1);
                check("t1_latency", 64'(output_write), 64'd0);
        step(); input_data = 6;
        mid();  check("t1_read1", 64'(input_read), 64'd1);
                check("t1_write1", 64'(output_write), 64'b111);
        step(); input_data = 7;
        mid();  check("t1_read2", 64'(input_read), 64'd1);
                check("t1_write2", 64'(output_write), 64'b111);
        step(); input_avail = 1'b0;
        mid();  check("t1_read3", 64'(input_read), 64'd0);
                check("t1_write3", 64'(output_write), 64'b111);
                check("t1_running", 64'(running), 64'd1);
        step();
        mid();  check("t5_write_idle", 64'(output_write), 64'd0);
                check("t5_running_fall", 64'(running), 64'd0);
        step();
        mid();  check("t5_running_low", 64'(running), 64'd0);
        step(); input_data = 99; input_avail = 1'b1;
        mid();  check("t5_running_still_low", 64'(running), 64'd0);
                check("t5_read", 64'(input_read), 64'd1);
        step(); input_avail = 1'b0;
        mid();  check("t5_running_rise", 64'(running), 64'd1);
                check("t5_write", 64'(output_write), 64'b111);
        drain();

        // Output 1 full for four cycles while 10, 11 (then 12) are offered.
        step(); output_full = 3'b010; input_data = 10; input_avail = 1'b1;
        mid();  check("t2_read0", 64'(input_read), 64'd1);
        step(); input_data = 11;
        mid();  check("t2_read1", 64'(input_read), 64'd1);
                check("t2_write1", 64'(output_write), 64'b101);
        step(); input_data = 12;
        mid();  check("t2_read_full2", 64'(input_read), 64'd0);
                check("t2_write2", 64'(output_write), 64'd0);
        step();
        mid();  check("t2_read_full3", 64'(input_read), 64'd0);
                check("t2_write3", 64'(output_write), 64'd0);
        step(); output_full = '0;
        mid();  check("t2_late_write", 64'(output_write), 64'b010);
                check("t2_no_passthru", 64'(input_read), 64'd0);
        step();
        mid();  check("t2_next_word", 64'(output_write), 64'b111);
                check("t2_read_resume", 64'(input_read), 64'd1);
        step(); input_avail = 1'b0;
        drain();

        // All outputs full with a full buffer, then release.
        step(); output_full = '1; input_data = 20; input_avail = 1'b1;
        mid();  check("t3_read0", 64'(input_read), 64'd1);
                check("t3_write0", 64'(output_write), 64'd0);
        step(); input_data = 21;
        mid();  check("t3_read1", 64'(input_read), 64'd1);
        step(); input_data = 22;
        mid();  check("t3_read_blocked", 64'(input_read), 64'd0);
                check("t3_write_blocked", 64'(output_write), 64'd0);
        step();
        mid();  check("t3_read_blocked2", 64'(input_read), 64'd0);
        step(); output_full = '0;
        mid();  check("t3_release_write", 64'(output_write), 64'b111);
                check("t3_release_no_read", 64'(input_read), 64'd0);
        step();
        mid();  check("t3_read_after_pop", 64'(input_read), 64'd1);
                check("t3_write_next", 64'(output_write), 64'b111);
        step(); input_avail = 1'b0;
        drain();

        // Reset with two buffered words and output 1 still pending.
        step(); output_full = 3'b010; input_data = 30; input_avail = 1'b1;
        mid();  check("t4_read0", 64'(input_read), 64'd1);
        step(); input_data = 31;
        mid();  check("t4_write1", 64'(output_write), 64'b101);
        step(); rst = 1'b1; output_full = '0; input_data = 32;
        mid();  check("t4_rst_read", 64'(input_read), 64'd0);
                check("t4_rst_write", 64'(output_write), 64'd0);
        step(); rst = 1'b0; input_avail = 1'b0;
        mid();  check("t4_running", 64'(running), 64'd1);
                check("t4_empty_write", 64'(output_write), 64'd0);
        step(); input_data = 33; input_avail = 1'b1;
        mid();  check("t4_read_after", 64'(input_read), 64'd1);
        step(); input_avail = 1'b0;
        mid();  check("t4_write_after", 64'(output_write), 64'b111);
        drain();

`ifdef KERNEL_DUPN_MASK_EN
        // Masked words: -1 only to outputs 0 and 2, 42 to nobody.
        step(); output_enable = 3'b101; input_data = 32'hFFFF_FFFF; input_avail = 1'b1;
        mid();  check("t6_read0", 64'(input_read), 64'd1);
        step(); output_enable = 3'b000; input_data = 42;
        mid();  check("t6_read1", 64'(input_read), 64'd1);
                check("t6_write_masked", 64'(output_write), 64'b101);
        step(); output_enable = 3'b111; input_data = 7;
        mid();  check("t6_zero_mask_write", 64'(output_write), 64'd0);
                check("t6_read2", 64'(input_read), 64'd1);
        step(); input_avail = 1'b0;
        mid();  check("t6_write_after", 64'(output_write), 64'b111);
        drain();
`endif

        step();
        step();
        check("final_empty", 64'(pending_words()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
